// File: rtl/link_credit_out.sv
// link_credit_out: four-port output link stage between the pipeline_two flit
// buffer and the neighbouring router. Each port (0=N, 1=S, 2=E, 3=W) has its
// own FIFO and downstream credit counter. A flit leaves only when the FIFO is
// non-empty and at least one downstream credit is held. Upstream is
// back-pressured through in_rdy, so no flit is ever dropped.
//
// Optional feature macro: LINK_STALL_CNT_EN
//   defined   -> per-port saturating counters of cycles spent blocked on credit
//   undefined -> stall_cnt is tied to zero and no counter logic exists
module link_credit_out #(
  parameter int FLIT_W  = 10,
  parameter int DEPTH   = 4,
  parameter int CREDITS = 4,
  parameter int STALL_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [4*FLIT_W-1:0]  in_flit,
  input  logic [3:0]           in_vld,
  output logic [3:0]           in_rdy,
  output logic [4*FLIT_W-1:0]  out_flit,
  output logic [3:0]           out_vld,
  input  logic [3:0]           cred_ret,
  output logic [3:0]           cred_err,
  output logic [4*STALL_W-1:0] stall_cnt
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = $clog2(DEPTH + 1);
  localparam int CRED_W = $clog2(CREDITS + 1);

  localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(DEPTH);
  localparam logic [CRED_W-1:0] CRED_MAX = CRED_W'(CREDITS);

  // Ports are fully independent, so every port gets an identical slice of logic.
  for (genvar d = 0; d < 4; d++) begin : g_port
    logic [FLIT_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic [CRED_W-1:0] credit;
    logic [FLIT_W-1:0] out_q;
    logic              vld_q;
    logic              err_q;
    logic              full;
    logic              push;
    logic              send;

    // Ready depends only on stored occupancy; a same-cycle pop never frees a slot early.
    assign full = (count == FULL_CNT);
    assign push = in_vld[d] & ~full;
    assign send = (count != '0) & (credit != '0);

    // Flit storage; count gates every read, so the array itself needs no reset.
    always_ff @(posedge clk) begin
      if (push) begin
        mem[wr_ptr] <= in_flit[d*FLIT_W +: FLIT_W];
      end
    end

    // Pointers wrap naturally at DEPTH (power of two); count tracks occupancy 0..DEPTH.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) begin
          wr_ptr <= wr_ptr + PTR_W'(1);
        end
        if (send) begin
          rd_ptr <= rd_ptr + PTR_W'(1);
        end
        case ({push, send})
          2'b10:   count <= count + CNT_W'(1);
          2'b01:   count <= count - CNT_W'(1);
          default: count <= count;
        endcase
      end
    end

    // Credit bookkeeping: a send consumes one, a return restores one, both together cancel.
    // A return arriving with a full credit count is dropped and latched as an error.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        credit <= CRED_MAX;
        err_q  <= 1'b0;
      end else begin
        case ({cred_ret[d], send})
          2'b01: credit <= credit - CRED_W'(1);
          2'b10: begin
            if (credit == CRED_MAX) begin
              err_q <= 1'b1;
            end else begin
              credit <= credit + CRED_W'(1);
            end
          end
          default: credit <= credit;
        endcase
      end
    end

    // Registered link output; the flit bus holds its last value between sends.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        out_q <= '0;
        vld_q <= 1'b0;
      end else begin
        vld_q <= send;
        if (send) begin
          out_q <= mem[rd_ptr];
        end
      end
    end

    assign in_rdy[d]                     = ~full;
    assign out_vld[d]                    = vld_q;
    assign out_flit[d*FLIT_W +: FLIT_W]  = out_q;
    assign cred_err[d]                   = err_q;

`ifdef LINK_STALL_CNT_EN
    logic [STALL_W-1:0] stall_q;

    // Count cycles where a flit is waiting but no credit is available; saturate at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        stall_q <= '0;
      end else if ((count != '0) && (credit == '0) && (stall_q != '1)) begin
        stall_q <= stall_q + STALL_W'(1);
      end
    end

    assign stall_cnt[d*STALL_W +: STALL_W] = stall_q;
`else
    assign stall_cnt[d*STALL_W +: STALL_W] = '0;
`endif
  end

endmodule

// File: tb/tb_link_credit_out.sv
// tb_link_credit_out: scoreboard bench for link_credit_out. A queue-based
// reference model advances on every active edge from the stimulus the bench
// drives; flits it predicts are sent go into per-port expectation queues,
// and an independent monitor pops and compares them whenever out_vld is seen.
module tb_link_credit_out;

  localparam int FLIT_W  = 10;
  localparam int DEPTH   = 4;
  localparam int CREDITS = 4;
  localparam int STALL_W = 16;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic [3:0]           in_vld = '0;
  logic [3:0]           cred_ret = '0;
  logic [FLIT_W-1:0]    src [4];
  logic [4*FLIT_W-1:0]  in_flit;
  logic [3:0]           in_rdy;
  logic [4*FLIT_W-1:0]  out_flit;
  logic [3:0]           out_vld;
  logic [3:0]           cred_err;
  logic [4*STALL_W-1:0] stall_cnt;

  assign in_flit = {src[3], src[2], src[1], src[0]};

  link_credit_out #(
    .FLIT_W (FLIT_W),
    .DEPTH  (DEPTH),
    .CREDITS(CREDITS),
    .STALL_W(STALL_W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_flit  (in_flit),
    .in_vld   (in_vld),
    .in_rdy   (in_rdy),
    .out_flit (out_flit),
    .out_vld  (out_vld),
    .cred_ret (cred_ret),
    .cred_err (cred_err),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  // Reference model state: FIFO contents as queues, credits as plain integers.
  logic [FLIT_W-1:0] m_fifo [4][$];
  logic [FLIT_W-1:0] exp_q  [4][$];
  logic [FLIT_W-1:0] exp_last [4];
  int                m_cred  [4];
  int                m_stall [4];
  logic [3:0]        m_err;
  logic [3:0]        exp_vld;
  logic [3:0]        acc;
  logic [FLIT_W-1:0] mon_f;

  int checks = 0;
  int errors = 0;

  function automatic void check(string name, int d, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s port %0d: got 0x%0h, expected 0x%0h", name, d, act, exp);
    end
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 4; d++) begin
      m_fifo[d].delete();
      exp_q[d].delete();
      exp_last[d] = '0;
      m_cred[d]   = CREDITS;
      m_stall[d]  = 0;
    end
    m_err   = '0;
    exp_vld = '0;
    acc     = '0;
  endtask

  // Apply the link rules for one active edge using the inputs currently driven.
  task automatic model_step();
    int                sz;
    bit                snd;
    logic [FLIT_W-1:0] f;
    for (int d = 0; d < 4; d++) begin
      sz  = m_fifo[d].size();
      snd = (sz != 0) && (m_cred[d] != 0);
      if (sz != 0 && m_cred[d] == 0 && m_stall[d] < (1 << STALL_W) - 1) m_stall[d]++;
      acc[d]     = in_vld[d] && (sz < DEPTH);
      exp_vld[d] = snd;
      if (snd) begin
        f = m_fifo[d].pop_front();
        exp_q[d].push_back(f);
        exp_last[d] = f;
      end
      if (acc[d]) m_fifo[d].push_back(src[d]);
      if (snd && !cred_ret[d]) m_cred[d]--;
      else if (!snd && cred_ret[d]) begin
        if (m_cred[d] == CREDITS) m_err[d] = 1'b1;
        else m_cred[d]++;
      end
    end
  endtask

  // One clock: the model advances at the edge, then inputs may change 1 time unit later.
  task automatic apply_stimulus();
    @(posedge clk);
    if (rst_n) model_step();
    #1;
  endtask

  // Return credits only where the model says some are outstanding.
  task automatic set_returns(input logic [3:0] mask);
    for (int d = 0; d < 4; d++) cred_ret[d] = mask[d] && (m_cred[d] < CREDITS);
  endtask

  task automatic drain(input int n);
    in_vld = '0;
    for (int i = 0; i < n; i++) begin
      set_returns(4'hF);
      apply_stimulus();
    end
    cred_ret = '0;
  endtask

  // Monitor: compares DUT outputs against the model half a cycle after each edge.
  always @(negedge clk) begin
    for (int d = 0; d < 4; d++) begin
      check("in_rdy", d, in_rdy[d], (m_fifo[d].size() < DEPTH));
      check("out_vld", d, out_vld[d], exp_vld[d]);
      if (out_vld[d]) begin
        if (exp_q[d].size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_flit port %0d: got 0x%0h, expected no flit", d,
                   out_flit[d*FLIT_W +: FLIT_W]);
        end else begin
          mon_f = exp_q[d].pop_front();
          check("out_flit", d, out_flit[d*FLIT_W +: FLIT_W], mon_f);
        end
      end else begin
        check("out_hold", d, out_flit[d*FLIT_W +: FLIT_W], exp_last[d]);
      end
      check("cred_err", d, cred_err[d], m_err[d]);
`ifdef LINK_STALL_CNT_EN
      check("stall_cnt", d, stall_cnt[d*STALL_W +: STALL_W], m_stall[d]);
`else
      check("stall_cnt", d, stall_cnt[d*STALL_W +: STALL_W], 0);
`endif
    end
  end

  int n;
  logic h1, h2;

  initial begin
    for (int d = 0; d < 4; d++) src[d] = '0;
    model_reset();
    repeat (3) apply_stimulus();
    check("reset_rdy", 0, in_rdy, 4'hF);
    rst_n = 1'b1;

    // Latency: flit pushed into an empty FIFO appears after the following edge, for one cycle.
    in_vld[0] = 1'b1;
    src[0]    = 10'h2A5;
    apply_stimulus();
    in_vld = '0;
    check("lat_early", 0, out_vld, 4'b0000);
    apply_stimulus();
    check("lat_vld", 0, out_vld, 4'b0001);
    check("lat_flit", 0, out_flit[FLIT_W-1:0], 10'h2A5);
    apply_stimulus();
    check("lat_once", 0, out_vld, 4'b0000);
    drain(3);

    // Credit block on E: nine flits, no returns.
    n = 0;
    for (int i = 0; i < 12; i++) begin
      in_vld[2] = (n < 9);
      src[2]    = FLIT_W'(10'h100 + n);
      apply_stimulus();
      if (acc[2]) n++;
    end
    check("blk_rdy", 2, in_rdy[2], 1'b0);
    cred_ret[2] = 1'b1;
    apply_stimulus();
    cred_ret[2] = 1'b0;
    apply_stimulus();
    check("blk_resume_rdy", 2, in_rdy[2], 1'b1);
    for (int i = 0; i < 4; i++) begin
      in_vld[2] = (n < 9);
      src[2]    = FLIT_W'(10'h100 + n);
      apply_stimulus();
      if (acc[2]) n++;
    end
    drain(14);

    // Simultaneous return and send on a full S FIFO holding one credit.
    n = 0;
    for (int i = 0; i < 15; i++) begin
      in_vld[1] = (n < 8);
      src[1]    = FLIT_W'(10'h200 + n);
      apply_stimulus();
      if (acc[1]) n++;
    end
    in_vld[1]   = 1'b1;
    src[1]      = 10'h2FF;
    cred_ret[1] = 1'b1;
    apply_stimulus();
    apply_stimulus();
    cred_ret[1] = 1'b0;
    for (int i = 0; i < 5; i++) begin
      apply_stimulus();
      if (acc[1]) in_vld[1] = 1'b0;
    end
    drain(14);

    // W stream of 0..19 with credits looped back two cycles after each send.
    n  = 0;
    h1 = 1'b0;
    h2 = 1'b0;
    for (int i = 0; i < 60; i++) begin
      in_vld[3]   = (n < 20);
      src[3]      = FLIT_W'(n);
      cred_ret[3] = h2;
      apply_stimulus();
      h2 = h1;
      h1 = exp_vld[3];
      if (acc[3]) n++;
    end
    drain(8);

    // Reset mid-stream with N blocked: credits 0, three flits buffered.
    n = 0;
    for (int i = 0; i < 10; i++) begin
      in_vld[0] = (n < 7);
      src[0]    = FLIT_W'(10'h300 + n);
      apply_stimulus();
      if (acc[0]) n++;
    end
    rst_n  = 1'b0;
    in_vld = '0;
    model_reset();
    #1;
    check("rst_vld", 0, out_vld, 4'b0000);
    check("rst_rdy", 0, in_rdy, 4'hF);
    apply_stimulus();
    apply_stimulus();
    rst_n = 1'b1;
    repeat (3) apply_stimulus();

    // Spurious return on N with a full credit count, then a long credit stall on N.
    cred_ret[0] = 1'b1;
    apply_stimulus();
    cred_ret[0] = 1'b0;
    check("err_dir", 0, cred_err, 4'b0001);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      in_vld[0] = (n < 5);
      src[0]    = FLIT_W'(10'h350 + n);
      apply_stimulus();
      if (acc[0]) n++;
    end
    drain(10);

    // Randomised traffic on all ports; upstream holds a flit until accepted.
    in_vld = '0;
    for (int i = 0; i < 400; i++) begin
      for (int d = 0; d < 4; d++) begin
        if (!in_vld[d] || acc[d]) begin
          in_vld[d] = ($urandom_range(0, 3) != 0);
          src[d]    = FLIT_W'($urandom);
        end
        cred_ret[d] = ($urandom_range(0, 2) != 0) && (m_cred[d] < CREDITS);
      end
      apply_stimulus();
    end
    drain(20);
    apply_stimulus();
    apply_stimulus();

    for (int d = 0; d < 4; d++) check("sb_empty", d, exp_q[d].size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
